muldiv: RTL

Multiply/divide unit for the HI/LO path of the CPU. Accepts one MULT/MULTU/DIV/DIVU (optionally MADD/MSUB family) operation from the EX stage, computes the 64-bit {hi, lo} result over multiple cycles, and emits it with a one-cycle write pulse into the HI/LO register. While an operation is in flight it holds `busy` so the pipeline stalls.

---
 rtl/muldiv.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/muldiv.sv
// muldiv: multi-cycle multiply/divide unit for the HI/LO path (single-cycle multiply, 32-step restoring divide).
// Optional accumulate ops (MADD/MADDU/MSUB/MSUBU) are enabled by defining MULDIV_MADD_EN.
module muldiv (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [63:0] hilo_cur,
    input  logic        cancel,
    output logic        busy,
    output logic        hilo_we,
    output logic [63:0] hilo_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_DONE = 2'd3
    } state_e;

    state_e      state_q, state_d;
    logic [2:0]  op_q, op_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;      // raw multiplier, or divisor magnitude
    logic [31:0] quo_q, quo_d;  // dividend bits shift out as quotient bits shift in
    logic [31:0] rem_q, rem_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [63:0] res_q, res_d;
    logic        q_neg_q, q_neg_d;
    logic        r_neg_q, r_neg_d;
    logic        dz_q, dz_d;
`ifdef MULDIV_MADD_EN
    logic [63:0] acc_q, acc_d;
`endif

    // Decode of the incoming request.
    logic        op_ok;
    logic        is_mul;
    logic        a_neg, b_neg;
    logic [31:0] a_mag, b_mag;

`ifdef MULDIV_MADD_EN
    assign op_ok = 1'b1;
`else
    assign op_ok = ~op[2];
`endif
    // Every 1xx op is a multiply-accumulate, regardless of op[1].
    assign is_mul = op[2] | ~op[1];
    assign a_neg  = ~op[0] & a[31];
    assign b_neg  = ~op[0] & b[31];
    assign a_mag  = a_neg ? (32'd0 - a) : a;
    assign b_mag  = b_neg ? (32'd0 - b) : b;

    // Multiply datapath.
    logic [63:0] prod_u, prod_s, prod, mul_res;
    assign prod_u = {32'd0, a_q} * {32'd0, b_q};
    assign prod_s = {{32{a_q[31]}}, a_q} * {{32{b_q[31]}}, b_q};
    assign prod   = op_q[0] ? prod_u : prod_s;

`ifdef MULDIV_MADD_EN
    assign mul_res = ~op_q[2] ? prod : (op_q[1] ? (acc_q - prod) : (acc_q + prod));
`else
    assign mul_res = prod;
    logic unused_ok;
    assign unused_ok = ^{hilo_cur, op_q[2:1]};
`endif

    // One restoring-division step; the 33-bit difference's top bit is the borrow.
    logic [32:0] rem_sh, diff;
    logic        ge;
    logic [31:0] rem_nx, quo_nx, q_fix, r_fix;
    logic [63:0] div_res;
    assign rem_sh  = {rem_q, quo_q[31]};
    assign diff    = rem_sh - {1'b0, b_q};
    assign ge      = ~diff[32];
    assign rem_nx  = ge ? diff[31:0] : rem_sh[31:0];
    assign quo_nx  = {quo_q[30:0], ge};
    assign q_fix   = q_neg_q ? (32'd0 - quo_nx) : quo_nx;
    assign r_fix   = r_neg_q ? (32'd0 - rem_nx) : rem_nx;
    assign div_res = dz_q ? {a_q, 32'hFFFF_FFFF} : {r_fix, q_fix};

    // NOTE: every variable gets its hold value first so no path leaves it unassigned (no latches).
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        cnt_d   = cnt_q;
        res_d   = res_q;
        q_neg_d = q_neg_q;
        r_neg_d = r_neg_q;
        dz_d    = dz_q;
`ifdef MULDIV_MADD_EN
        acc_d   = acc_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start && op_ok) begin
                    op_d    = op;
                    a_d     = a;
                    b_d     = is_mul ? b : b_mag;
                    quo_d   = a_mag;
                    rem_d   = 32'd0;
                    cnt_d   = 5'd0;
                    q_neg_d = a_neg ^ b_neg;
                    r_neg_d = a_neg;
                    dz_d    = (b == 32'd0);
`ifdef MULDIV_MADD_EN
                    acc_d   = hilo_cur;
`endif
                    state_d = is_mul ? S_MUL : S_DIV;
                end
            end
            S_MUL: begin
                res_d   = mul_res;
                state_d = S_DONE;
            end
            S_DIV: begin
                rem_d = rem_nx;
                quo_d = quo_nx;
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd31) begin
                    res_d   = div_res;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        // A flush aborts the operation and must not disturb the visible result.
        if (cancel) begin
            state_d = S_IDLE;
            res_d   = res_q;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            op_q    <= 3'd0;
            a_q     <= 32'd0;
            b_q     <= 32'd0;
            quo_q   <= 32'd0;
            rem_q   <= 32'd0;
            cnt_q   <= 5'd0;
            res_q   <= 64'd0;
            q_neg_q <= 1'b0;
            r_neg_q <= 1'b0;
            dz_q    <= 1'b0;
`ifdef MULDIV_MADD_EN
            acc_q   <= 64'd0;
`endif
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
            q_neg_q <= q_neg_d;
            r_neg_q <= r_neg_d;
            dz_q    <= dz_d;
`ifdef MULDIV_MADD_EN
            acc_q   <= acc_d;
`endif
        end
    end

    assign busy    = (state_q != S_IDLE);
    assign hilo_we = (state_q == S_DONE);
    assign hilo_o  = res_q;

endmodule
